unpool_stride: RTL and testbench
================================

// Module: unpool_stride
// PURPOSE
//  Inverse of the maxpool stride decimator: expands a decimated feature-map stream
//  (WIDTH/STRIDE x WIDTH/STRIDE) back to a full WIDTH x WIDTH raster.
//  Expansion is nearest-neighbour (replicate) or zero-insert.
//  Sits after the pooling stage in the decoder/upsample path.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  STRIDE  2   upsample factor per axis; WIDTH % STRIDE == 0 required
//  WIDTH   32  output frame width = height, in pixels (max 1023)
//  DATA_W  8   pixel width in bits
//  MODE    0   0 = nearest-neighbour replicate, 1 = zero-insert
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  reset      in   1       synchronous, active-high reset
//  in_valid   in   1       input pixel valid
//  in_ready   out  1       block accepts in_data this cycle
//  in_data    in   DATA_W  decimated pixel, raster order
//  out_valid  out  1       out_data valid
//  out_ready  in   1       downstream accepts out_data
//  out_data   out  DATA_W  upsampled pixel, raster order
//  out_eol    out  1       qualifies out_data: last column of a row (c == WIDTH-1)
//  out_eof    out  1       qualifies out_data: last pixel of the frame
//  frame_done out  1       one-cycle pulse when the out_eof pixel is handshaken
// BEHAVIOUR
//  Reset values:
//   - out_valid, out_data, out_eol, out_eof, frame_done all 0
//   - output position counters c, r = 0
//   - in_ready forced 0 while reset = 1
//   - line buffer is not cleared
//  Position counters:
//   - c, r (10 bit) give the raster position of the NEXT pixel to generate.
//   - c increments on each generated pixel. At c == WIDTH-1, c wraps to 0 and r increments.
//   - At r == WIDTH-1 and c == WIDTH-1, both wrap to 0.
//  Definitions:
//   - need_in = (r%STRIDE==0) && (c%STRIDE==0)
//   - slot_free = !out_valid || out_ready
//   - in_ready = need_in && slot_free   (combinational)
//  Generate condition: slot_free && (!need_in || in_valid).
//   On a generate cycle the output register loads and the counters advance.
//   Otherwise out_valid <= out_valid && !out_ready.
//  Output data rules:
//   - need_in: out_data <= in_data.
//     If r%STRIDE==0, in_data is also written to linebuf[c/STRIDE].
//   - Nearest, r%STRIDE==0, c%STRIDE!=0: out_data <= held sample (last accepted in_data).
//   - Nearest, r%STRIDE!=0: out_data <= linebuf[c/STRIDE].
//   - Zero-insert, any non-need_in position: out_data <= 0.
//  Line buffer: WIDTH/STRIDE x DATA_W register array, written synchronously, read
//   asynchronously. Row 0 of each stride band always rewrites an entry before it is read.
//  Latency: 1 cycle from input handshake to out_valid.
//  Throughput: 1 pixel/cycle when out_ready = 1 and input never starves.
//  Backpressure: while out_valid && !out_ready, out_data/out_eol/out_eof are held stable,
//   counters are frozen, and in_ready = 0.
//  Starvation: at a need_in position with in_valid = 0, nothing advances and out_valid
//   falls once the current pixel drains. No bubble pixel is ever emitted.
//  Frame sequencing:
//   - frame_done <= 1 for exactly one cycle after an out_eof handshake.
//   - The next frame starts at (0,0) on the following generate, back-to-back with no gap.
//  Reset mid-frame: partial frame discarded; the next accepted input is pixel (0,0).
// TESTING  (STRIDE=2, WIDTH=4, DATA_W=8 unless stated)
//  1. MODE=0, in = 1,2,3,4, out_ready = 1
//     -> out = 1 1 2 2 / 1 1 2 2 / 3 3 4 4 / 3 3 4 4
//     -> out_eol on pixels 3, 7, 11, 15; out_eof and frame_done on pixel 15
//  2. MODE=1, same input
//     -> out = 1 0 2 0 / 0 0 0 0 / 3 0 4 0 / 0 0 0 0
//  3. Backpressure: out_ready = 0 for 3 cycles while out_data = 2
//     -> out_data holds 2, in_ready = 0, no counter advance
//     -> resumes with the correct sequence afterwards
//  4. Starvation: in_valid = 0 for 5 cycles at position (2,0)
//     -> out_valid drops after the pending pixel drains, no bubble pixel
//     -> out = 3 follows once in_valid = 1
//  5. Two frames back-to-back (in = 1..4 then 5..8), out_ready = 1
//     -> 32 consecutive out_valid cycles
//     -> frame_done pulses twice, 16 cycles apart
//  6. reset = 1 at output pixel 6 of a frame, then a fresh frame 9,8,7,6
//     -> all outputs 0 during reset
//     -> frame 2 output exactly 9 9 8 8 / 9 9 8 8 / 7 7 6 6 / 7 7 6 6

Source files
------------

// File: rtl/unpool_stride.sv
// Stride unpooler: expands a decimated raster to WIDTH x WIDTH (replicate or zero-insert), 1-cycle latency.
// Single output register; stalls hold outputs, freeze counters and drop in_ready until drained.
module unpool_stride #(
    parameter int STRIDE = 2,
    parameter int WIDTH  = 32,
    parameter int DATA_W = 8,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done
);

    localparam int         NCOL  = WIDTH / STRIDE;
    localparam int         IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [9:0] LAST  = 10'(WIDTH - 1);
    localparam logic [9:0] STR   = 10'(STRIDE);

    logic [9:0]        c_q, c_d, r_q, r_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_eol_q, out_eol_d;
    logic              out_eof_q, out_eof_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] linebuf_q [NCOL];
    logic [DATA_W-1:0] linebuf_d [NCOL];

    logic             row_in, col_in, need_in, slot_free, gen;
    logic [IDX_W-1:0] lb_idx;

    always_comb begin
        row_in    = (r_q % STR) == 10'd0;
        col_in    = (c_q % STR) == 10'd0;
        need_in   = row_in && col_in;
        slot_free = !out_valid_q || out_ready;
        in_ready  = need_in && slot_free && !reset;
        gen       = slot_free && (!need_in || in_valid);
        lb_idx    = IDX_W'(c_q / STR);
    end

    always_comb begin
        c_d          = c_q;
        r_d          = r_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_eol_d    = out_eol_q;
        out_eof_d    = out_eof_q;
        frame_done_d = out_valid_q && out_ready && out_eof_q;
        hold_d       = hold_q;
        linebuf_d    = linebuf_q;
        if (gen) begin
            out_valid_d = 1'b1;
            out_eol_d   = (c_q == LAST);
            out_eof_d   = (c_q == LAST) && (r_q == LAST);
            if (need_in) begin
                // every sampled position lies on a band's first row, so it also refreshes the line buffer
                out_data_d        = in_data;
                hold_d            = in_data;
                linebuf_d[lb_idx] = in_data;
            end else if (MODE != 0) begin
                out_data_d = '0;
            end else if (row_in) begin
                out_data_d = hold_q;
            end else begin
                out_data_d = linebuf_q[lb_idx];
            end
            if (c_q == LAST) begin
                c_d = 10'd0;
                r_d = (r_q == LAST) ? 10'd0 : r_q + 10'd1;
            end else begin
                c_d = c_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q          <= 10'd0;
            r_q          <= 10'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            c_q          <= c_d;
            r_q          <= r_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    // sample storage is never read before being rewritten, so it needs no reset
    always_ff @(posedge clk) begin
        hold_q    <= hold_d;
        linebuf_q <= linebuf_d;
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_unpool_stride.sv
// Bench for unpool_stride: replicate and zero-insert instances share stimulus, checked against a frame-index model.
module tb_unpool_stride;

    localparam int S = 2, W = 4, DW = 8;
    localparam int NCOL = W / S, NIN = NCOL * NCOL, NPIX = W * W;

    logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          irdy0, ov0, eol0, eof0, fd0;
    logic          irdy1, ov1, eol1, eof1, fd1;
    logic [DW-1:0] od0, od1;

    unpool_stride #(.STRIDE(S), .WIDTH(W), .DATA_W(DW), .MODE(0)) u_nn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(irdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_eol(eol0),
        .out_eof(eof0), .frame_done(fd0));

    unpool_stride #(.STRIDE(S), .WIDTH(W), .DATA_W(DW), .MODE(1)) u_zi (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(irdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_eol(eol1),
        .out_eof(eof1), .frame_done(fd1));

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] acc[$];
    logic [DW-1:0] src[$];
    int  out_k = 0, pv = 100, pr = 100, rst_cnt = 3, cyc = 0;
    bit  pending = 0, prev_reset = 0, prev_eof_hs = 0, prev_stall = 0, prev_in_hs = 0;
    logic [DW-1:0] prev_in, prev_od0, prev_od1;
    int  stall_left = 0, starve_left = 0;
    bit  stall_armed = 0, starve_armed = 0;
    bit  t5 = 0;
    int  t5_hs = 0, t5_first = 0, t5_last = 0;
    int  fd_cyc[$];

    task automatic step();
        int g, p, rr, cc, k, idx;
        bit need, sf, ihs, ohs, starve_end;
        logic [DW-1:0] e0, e1;
        @(negedge clk);
        reset = (rst_cnt > 0);
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (stall_armed && ov0 && od0 == 8'd2) begin
            out_ready   = 1'b0;
            stall_left  = 2;
            stall_armed = 0;
        end else begin
            out_ready = ($urandom_range(99) < pr);
        end
        g = out_k + int'(ov0);
        starve_end = 0;
        if (starve_armed && !reset && g % NPIX == 8 && acc.size() % NIN == 2) begin
            starve_left  = 5;
            starve_armed = 0;
        end
        if (starve_left > 0) begin
            in_valid   = 1'b0;
            starve_end = (starve_left == 1);
            starve_left--;
        end else if (src.size() > 0) begin
            if (!pending) pending = ($urandom_range(99) < pv);
            in_valid = pending;
            in_data  = src[0];
        end else begin
            in_valid = 1'b0;
            pending  = 0;
        end
        #1;
        p    = g % NPIX;
        need = ((p / W) % S == 0) && ((p % W) % S == 0);
        sf   = !ov0 || out_ready;
        ihs  = in_valid && irdy0;
        ohs  = ov0 && out_ready;
        if (reset) begin
            check("rst_in_ready", {irdy0, irdy1}, 0);
            if (prev_reset)
                check("rst_outputs", {ov0, od0, eol0, eof0, fd0, ov1, od1, eol1, eof1, fd1}, 0);
        end else begin
            check("in_ready_nn", irdy0, need && sf);
            check("in_ready_zi", irdy1, need && sf);
            check("valid_pair", ov1, ov0);
            check("frame_done", {fd0, fd1}, {prev_eof_hs, prev_eof_hs});
            if (prev_stall) check("stall_hold", {ov0, od0, od1}, {1'b1, prev_od0, prev_od1});
            if (prev_in_hs) check("latency", {ov0, od0, od1}, {1'b1, prev_in, prev_in});
            if (starve_end) check("starve_drain", ov0, 0);
            if (ohs) begin
                k   = out_k;
                rr  = (k % NPIX) / W;
                cc  = (k % NPIX) % W;
                idx = (k / NPIX) * NIN + (rr / S) * NCOL + cc / S;
                check("input_avail", idx < acc.size(), 1);
                if (idx < acc.size()) begin
                    e0 = acc[idx];
                    e1 = (rr % S == 0 && cc % S == 0) ? e0 : '0;
                    check("data_nn", od0, e0);
                    check("data_zi", od1, e1);
                end
                check("eol", {eol0, eol1}, {2{cc == W - 1}});
                check("eof", {eof0, eof1}, {2{rr == W - 1 && cc == W - 1}});
            end
        end
        cyc++;
        if (fd0 && !reset) fd_cyc.push_back(cyc);
        if (t5 && ohs) begin
            if (t5_hs == 0) t5_first = cyc;
            t5_last = cyc;
            t5_hs++;
        end
        prev_reset  = reset;
        prev_stall  = !reset && ov0 && !out_ready;
        prev_eof_hs = !reset && ohs && eof0;
        prev_in_hs  = !reset && ihs;
        prev_in     = in_data;
        prev_od0    = od0;
        prev_od1    = od1;
        if (reset) begin
            acc.delete();
            out_k = 0;
            rst_cnt--;
        end else begin
            if (ihs) begin
                acc.push_back(in_data);
                void'(src.pop_front());
                pending = 0;
            end
            if (ohs) out_k++;
        end
    endtask

    task automatic run_until_out(input int target, input int budget);
        int n = 0;
        while (out_k < target && n < budget) begin
            step();
            n++;
        end
        check("progress", out_k, target);
        repeat (2) step();
    endtask

    task automatic load_seq(input int first, input int cnt, input int dir);
        for (int i = 0; i < cnt; i++) src.push_back(8'(first + dir * i));
    endtask

    initial begin
        int base, nfd;
        repeat (4) step();

        // replicate and zero-insert of 1..4 at full rate
        load_seq(1, 4, 1);
        run_until_out(16, 200);

        // three-cycle output stall while pixel 2 is presented
        stall_armed = 1;
        load_seq(1, 4, 1);
        run_until_out(32, 200);

        // input starved for five cycles at position (2,0)
        starve_armed = 1;
        load_seq(1, 4, 1);
        run_until_out(48, 200);

        // two frames back to back
        nfd = fd_cyc.size();
        t5  = 1;
        load_seq(1, 8, 1);
        run_until_out(80, 300);
        t5  = 0;
        check("t5_fd_count", fd_cyc.size() - nfd, 2);
        if (fd_cyc.size() >= 2) check("t5_fd_gap", fd_cyc[$] - fd_cyc[$-1], 16);
        check("t5_hs", t5_hs, 32);
        check("t5_span", t5_last - t5_first, 31);

        // reset at output pixel 6, then a fresh frame
        base = out_k;
        load_seq(1, 4, 1);
        run_until_out(base + 6, 200);
        src.delete();
        pending = 0;
        rst_cnt = 2;
        repeat (3) step();
        load_seq(9, 4, -1);
        run_until_out(16, 200);

        // random data with random valid/ready
        pv = 60;
        pr = 60;
        for (int f = 0; f < 8; f++)
            for (int i = 0; i < NIN; i++) src.push_back(8'($urandom_range(255)));
        run_until_out(16 + 8 * NPIX, 3000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
